soc_system_pio_clkgen: RTL and testbench



---
 rtl/soc_system_pio_clkgen.sv | 172 +++++++++++++++++
 tb/tb_soc_system_pio_clkgen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_clkgen.sv
// soc_system_pio_clkgen
//   WIDTH-bit Avalon-MM output port with atomic set/clear/toggle access and
//   a pulse-train generator driving out_port[0]. The HPS writes a half-period
//   (DIV) and a pulse count (BURST). The block then produces that many
//   pulses, each div+1 cycles high and div+1 cycles low.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     word address (0 DATA, 1 SET, 2 CLR, 3 TOG, 4 DIV, 5 BURST,
//               6 STATUS, 7 IRQ_EN)
//   chipselect  slave select (writes only; reads decode address alone)
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, combinational, zero wait states
//   out_port    output port, equal to the data register
//   irq         level interrupt = done & irq_en
module soc_system_pio_clkgen #(
  parameter int unsigned            WIDTH       = 8,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
  parameter int unsigned            DIV_WIDTH   = 16,
  parameter int unsigned            CNT_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_SET    = 3'd1,
    ADDR_CLR    = 3'd2,
    ADDR_TOG    = 3'd3,
    ADDR_DIV    = 3'd4,
    ADDR_BURST  = 3'd5,
    ADDR_STATUS = 3'd6,
    ADDR_IRQ_EN = 3'd7
  } addr_t;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     data, data_nxt;
  logic [DIV_WIDTH-1:0] div, div_nxt;
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] remaining, remaining_nxt;
  logic                 done, done_nxt;
  logic                 irq_en, irq_en_nxt;

  logic                 busy;
  logic                 wr;
  logic                 burst_wr;
  logic [CNT_WIDTH-1:0] burst_n;
  logic [WIDTH-1:0]     wd_w;
  logic [WIDTH-1:0]     hold_mask;

  assign busy      = (state != IDLE);
  assign wr        = chipselect & ~write_n;
  assign burst_wr  = wr && (address == ADDR_BURST);
  assign burst_n   = writedata[CNT_WIDTH-1:0];
  assign wd_w      = writedata[WIDTH-1:0];
  // While a burst runs, bit 0 belongs to the generator, so bus writes keep it.
  assign hold_mask = WIDTH'(busy);

  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    data_nxt      = data;
    div_nxt       = div;
    cnt_nxt       = cnt;
    remaining_nxt = remaining;
    done_nxt      = done;
    irq_en_nxt    = irq_en;

    if (wr) begin
      unique case (address)
        ADDR_DATA:   data_nxt = (wd_w          & ~hold_mask) | (data & hold_mask);
        ADDR_SET:    data_nxt = ((data | wd_w)  & ~hold_mask) | (data & hold_mask);
        ADDR_CLR:    data_nxt = ((data & ~wd_w) & ~hold_mask) | (data & hold_mask);
        ADDR_TOG:    data_nxt = ((data ^ wd_w)  & ~hold_mask) | (data & hold_mask);
        ADDR_DIV:    div_nxt  = writedata[DIV_WIDTH-1:0];
        ADDR_STATUS: if (writedata[1]) done_nxt = 1'b0;
        ADDR_IRQ_EN: irq_en_nxt = writedata[0];
        default: ;
      endcase
    end

    // The generator runs after the bus decode, so its updates to bit 0 and
    // to done take priority (a done set beats a same-cycle W1C).
    unique case (state)
      IDLE: begin
        if (burst_wr && (burst_n != '0)) begin
          remaining_nxt = burst_n;
          cnt_nxt       = div;
          data_nxt[0]   = 1'b1;
          state_nxt     = HIGH;
        end
      end
      HIGH, LOW: begin
        if (burst_wr && (burst_n == '0)) begin
          // Abort: drop the line and finish without flagging done.
          data_nxt[0]   = 1'b0;
          remaining_nxt = '0;
          state_nxt     = IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - DIV_WIDTH'(1);
        end else if (state == HIGH) begin
          data_nxt[0] = 1'b0;
          cnt_nxt     = div;
          state_nxt   = LOW;
        end else begin
          remaining_nxt = remaining - CNT_WIDTH'(1);
          if (remaining == CNT_WIDTH'(1)) begin
            data_nxt[0] = 1'b0;
            done_nxt    = 1'b1;
            state_nxt   = IDLE;
          end else begin
            data_nxt[0] = 1'b1;
            cnt_nxt     = div;
            state_nxt   = HIGH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      data      <= RESET_VALUE;
      div       <= '0;
      cnt       <= '0;
      remaining <= '0;
      done      <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      state     <= state_nxt;
      data      <= data_nxt;
      div       <= div_nxt;
      cnt       <= cnt_nxt;
      remaining <= remaining_nxt;
      done      <= done_nxt;
      irq_en    <= irq_en_nxt;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA:   readdata = 32'(data);
      ADDR_DIV:    readdata = 32'(div);
      ADDR_BURST:  readdata = 32'(remaining);
      ADDR_STATUS: readdata = {30'd0, done, busy};
      ADDR_IRQ_EN: readdata = {31'd0, irq_en};
      default:     readdata = '0;
    endcase
  end

  assign out_port = data;
  assign irq      = done & irq_en;

endmodule

// File: tb/tb_soc_system_pio_clkgen.sv
module tb_soc_system_pio_clkgen;

  localparam int unsigned      WIDTH = 8;
  localparam logic [WIDTH-1:0] RV    = 8'h5A;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard of expected values, pushed when stimulus is driven.
  logic [31:0] exp_q[$];

  soc_system_pio_clkgen #(
    .WIDTH(WIDTH), .RESET_VALUE(RV), .DIV_WIDTH(16), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write completes on the posedge; returns 1ns after it.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; #1; d = readdata;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int a = 0; a < 8; a++) exp_q.push_back(a == 0 ? 32'(RV) : 32'd0);
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      bus_read(3'(a), got);
      exp = exp_q.pop_front();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got 0x%08h expected 0x%08h", a, got, exp);
      end
    end
    n_tests++;
    if (out_port !== RV || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_port 0x%02h irq %b expected 0x%02h irq 0", out_port, irq, RV);
    end
  endtask

  task automatic test_data_ops();
    logic [2:0]  addrs[4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] wds[4]   = '{32'h1234_560F, 32'h0000_0030, 32'h0000_0001, 32'hFFFF_FFC3};
    logic [31:0] got, exp;
    exp_q.push_back(32'h0F); exp_q.push_back(32'h3F);
    exp_q.push_back(32'h3E); exp_q.push_back(32'hFD);
    for (int i = 0; i < 4; i++) begin
      bus_write(addrs[i], wds[i]);
      exp = exp_q.pop_front();
      n_tests++;
      if (out_port !== exp[WIDTH-1:0]) begin
        n_fail++;
        $display("FAIL data_op%0d_out_port: got 0x%02h expected 0x%02h", i, out_port, exp[WIDTH-1:0]);
      end
      bus_read(3'd0, got);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL data_op%0d_read: got 0x%08h expected 0x%08h", i, got, exp);
      end
      if (i > 0) begin
        bus_read(addrs[i], got);
        n_tests++;
        if (got !== 32'd0) begin
          n_fail++;
          $display("FAIL data_op%0d_strobe_read: got 0x%08h expected 0", i, got);
        end
      end
    end
  endtask

  task automatic test_burst();
    logic [31:0] got, e_out, e_rem, e_st;
    bus_write(3'd4, 32'h0001_0002);  // upper bits truncated -> div = 2
    bus_read(3'd4, got);
    n_tests++;
    if (got !== 32'd2) begin
      n_fail++;
      $display("FAIL div_read: got 0x%08h expected 0x2", got);
    end
    for (int c = 0; c < 18; c++) begin
      exp_q.push_back(((c / 3) % 2 == 0) ? 32'd1 : 32'd0);
      exp_q.push_back(32'(3 - c / 6));
      exp_q.push_back(32'd1);
    end
    bus_write(3'd5, 32'd3);
    for (int c = 0; c < 18; c++) begin
      e_out = exp_q.pop_front(); e_rem = exp_q.pop_front(); e_st = exp_q.pop_front();
      n_tests++;
      if (32'(out_port[0]) !== e_out || out_port[WIDTH-1:1] !== 7'h7E) begin
        n_fail++;
        $display("FAIL burst_out c%0d: got 0x%02h expected bit0 %0d upper 0x7E", c, out_port, e_out);
      end
      bus_read(3'd5, got);
      n_tests++;
      if (got !== e_rem) begin
        n_fail++;
        $display("FAIL burst_remaining c%0d: got %0d expected %0d", c, got, e_rem);
      end
      bus_read(3'd6, got);
      n_tests++;
      if (got !== e_st) begin
        n_fail++;
        $display("FAIL burst_status c%0d: got 0x%0h expected 0x%0h", c, got, e_st);
      end
      step();
    end
    bus_read(3'd6, got);
    n_tests++;
    if (got !== 32'h2 || out_port !== 8'hFC || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_end: status 0x%0h out 0x%02h irq %b expected 0x2 0xFC 0", got, out_port, irq);
    end
  endtask

  task automatic test_irq();
    logic [31:0] got;
    bus_write(3'd6, 32'h2);
    bus_write(3'd7, 32'h1);
    bus_write(3'd4, 32'h0);
    bus_read(3'd7, got);
    n_tests++;
    if (got !== 32'h1 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_setup: irq_en 0x%0h irq %b expected 0x1 0", got, irq);
    end
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    bus_write(3'd5, 32'd1);
    for (int c = 0; c < 3; c++) begin
      got = exp_q.pop_front();
      n_tests++;
      if (32'(irq) !== got) begin
        n_fail++;
        $display("FAIL irq_rise c%0d: got %b expected %0d", c, irq, got);
      end
      if (c < 2) step();
    end
    bus_write(3'd6, 32'h2);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: got %b expected 0", irq);
    end
  endtask

  task automatic test_busy_writes_and_abort();
    logic [31:0] got;
    bus_write(3'd7, 32'h0);
    bus_write(3'd4, 32'd4);
    bus_write(3'd5, 32'd10);                       // E0, pulse high
    bus_write(3'd0, 32'hA0);                       // E1
    n_tests++;
    if (out_port !== 8'hA1) begin
      n_fail++;
      $display("FAIL busy_data_write: got 0x%02h expected 0xA1", out_port);
    end
    repeat (3) step();                             // E4
    n_tests++;
    if (out_port !== 8'hA1) begin
      n_fail++;
      $display("FAIL pulse_high_hold: got 0x%02h expected 0xA1", out_port);
    end
    step();                                        // E5
    n_tests++;
    if (out_port !== 8'hA0) begin
      n_fail++;
      $display("FAIL pulse_fall: got 0x%02h expected 0xA0", out_port);
    end
    bus_write(3'd5, 32'd5);                        // E6, ignored
    bus_read(3'd5, got);
    n_tests++;
    if (got !== 32'd10) begin
      n_fail++;
      $display("FAIL busy_burst_ignored: remaining %0d expected 10", got);
    end
    bus_write(3'd5, 32'd0);                        // E7, abort
    bus_read(3'd6, got);
    n_tests++;
    if (got !== 32'd0 || out_port !== 8'hA0) begin
      n_fail++;
      $display("FAIL abort: status 0x%0h out 0x%02h expected 0x0 0xA0", got, out_port);
    end
    bus_read(3'd5, got);
    n_tests++;
    if (got !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_remaining: got %0d expected 0", got);
    end
    for (int c = 0; c < 12; c++) begin
      step();
      n_tests++;
      if (out_port !== 8'hA0) begin
        n_fail++;
        $display("FAIL abort_quiet c%0d: got 0x%02h expected 0xA0", c, out_port);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] got;
    bus_write(3'd5, 32'd3);                        // div still 4
    step();
    n_tests++;
    if (out_port !== 8'hA1) begin
      n_fail++;
      $display("FAIL pre_reset_high: got 0x%02h expected 0xA1", out_port);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    bus_read(3'd6, got);
    n_tests++;
    if (out_port !== RV || got !== 32'd0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: out 0x%02h status 0x%0h irq %b expected 0x%02h 0x0 0", out_port, got, irq, RV);
    end
    for (int c = 0; c < 20; c++) begin
      step();
      n_tests++;
      if (out_port !== RV) begin
        n_fail++;
        $display("FAIL post_reset_quiet c%0d: got 0x%02h expected 0x%02h", c, out_port, RV);
      end
    end
  endtask

  initial begin
    test_reset();
    test_data_ops();
    test_burst();
    test_irq();
    test_busy_writes_and_abort();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
